packet_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one registered packet output among NUM_REQ

---
 rtl/packet_rr_arbiter.sv | 101 ++++++++++
 tb/tb_packet_rr_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/packet_rr_arbiter.sv
// Round-robin packet arbiter. NUM_REQ requesters share one registered output slot
// that is tagged with the winner's source ID and held until the sink accepts it.

module rr_lane #(
  parameter int SRC_W = 2,
  parameter int IDX   = 0
) (
  input  logic             valid,
  input  logic [SRC_W-1:0] ptr,
  input  logic [SRC_W-1:0] grant,
  output logic             hi_pri,
  output logic             hit
);
  localparam logic [SRC_W-1:0] ID = SRC_W'(IDX);

  // Lanes at or above the pointer win over wrapped-around lanes.
  assign hi_pri = valid && (ID >= ptr);
  assign hit    = (grant == ID);
endmodule

module packet_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 8,
  parameter  int DEST_W  = 4,
  parameter  int CNT_W   = 16,
  localparam int SRC_W   = $clog2(NUM_REQ),
  localparam int PKT_W   = SRC_W + DEST_W + DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DEST_W-1:0] req_dest,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PKT_W-1:0]          out_packet,
  output logic [SRC_W-1:0]          grant_id,
  output logic [CNT_W-1:0]          pkt_count
);
  typedef enum logic {EMPTY, FULL} state_t;

  state_t                          state, state_nxt;
  logic [NUM_REQ-1:0][DEST_W-1:0]  dest_a;
  logic [NUM_REQ-1:0][DATA_W-1:0]  data_a;
  logic [NUM_REQ-1:0]              hi_pri, grant_oh;
  logic [SRC_W-1:0]                rr_ptr, grant;
  logic                            any_hi, load;

  assign dest_a = req_dest;
  assign data_a = req_data;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    rr_lane #(.SRC_W(SRC_W), .IDX(i)) u_lane (
      .valid  (req_valid[i]),
      .ptr    (rr_ptr),
      .grant  (grant),
      .hi_pri (hi_pri[i]),
      .hit    (grant_oh[i])
    );
  end

  // Lowest index among lanes >= rr_ptr, else lowest valid index overall.
  always_comb begin
    grant  = '0;
    any_hi = |hi_pri;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (any_hi ? hi_pri[i] : req_valid[i]) grant = SRC_W'(i);
  end

  assign out_valid = (state == FULL);
  assign load      = (|req_valid) && (!out_valid || out_ready);

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    if (load)           state_nxt = FULL;
    else if (out_ready) state_nxt = EMPTY;
    if (load && !rst)   req_ready = grant_oh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      out_packet <= '0;
      grant_id   <= '0;
      rr_ptr     <= '0;
      pkt_count  <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        out_packet <= {grant, dest_a[grant], data_a[grant]};
        grant_id   <= grant;
        rr_ptr     <= (grant == SRC_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
      end
      // Saturating count of sink accepts.
      if (out_valid && out_ready && !(&pkt_count))
        pkt_count <= pkt_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_packet_rr_arbiter.sv
// Randomized + directed bench for packet_rr_arbiter; a 4-requester and a
// 3-requester/4-bit-counter instance share stimulus, each checked by a reference model.

module tb_packet_rr_arbiter;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_dest;
  logic [31:0] req_data;
  logic        out_ready;

  logic [3:0]  a_ready;
  logic        a_valid;
  logic [13:0] a_pkt;
  logic [1:0]  a_gid;
  logic [15:0] a_cnt;

  logic [2:0]  b_ready;
  logic        b_valid;
  logic [13:0] b_pkt;
  logic [1:0]  b_gid;
  logic [3:0]  b_cnt;

  packet_rr_arbiter u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_dest(req_dest),
    .req_data(req_data), .req_ready(a_ready), .out_valid(a_valid),
    .out_ready(out_ready), .out_packet(a_pkt), .grant_id(a_gid), .pkt_count(a_cnt)
  );

  packet_rr_arbiter #(.NUM_REQ(3), .CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .req_valid(req_valid[2:0]), .req_dest(req_dest[11:0]),
    .req_data(req_data[23:0]), .req_ready(b_ready), .out_valid(b_valid),
    .out_ready(out_ready), .out_packet(b_pkt), .grant_id(b_gid), .pkt_count(b_cnt)
  );

  typedef struct {
    logic        full;
    logic [13:0] pkt;
    logic [1:0]  gid;
    int          ptr;
    int          cnt;
  } mdl_t;

  mdl_t ma, mb;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // One clock of the arbiter's rules, applied to the current inputs.
  task automatic mstep(input int n, input int cmax, inout mdl_t m, output logic [3:0] rdy);
    int   g;
    logic ld;
    g   = -1;
    rdy = '0;
    if (rst) begin
      m.full = 0; m.pkt = '0; m.gid = '0; m.ptr = 0; m.cnt = 0;
      return;
    end
    for (int k = 0; k < n; k++)
      if (g < 0 && req_valid[(m.ptr + k) % n]) g = (m.ptr + k) % n;
    ld = (g >= 0) && (!m.full || out_ready);
    if (m.full && out_ready && m.cnt < cmax) m.cnt++;
    if (ld) begin
      rdy    = 4'(1 << g);
      m.pkt  = {2'(g), req_dest[g*4 +: 4], req_data[g*8 +: 8]};
      m.gid  = 2'(g);
      m.full = 1'b1;
      m.ptr  = (g + 1) % n;
    end else if (out_ready) begin
      m.full = 1'b0;
    end
  endtask

  task automatic cyc(input logic r, input logic [3:0] v, input logic o, input bit keep = 0);
    logic [3:0] ea, eb;
    @(negedge clk);
    rst       = r;
    req_valid = v;
    out_ready = o;
    if (!keep) begin
      req_dest = 16'($urandom);
      req_data = $urandom;
    end
    #1;
    if (chk_en) begin
      chk("a_valid", 32'(a_valid), 32'(ma.full));
      chk("a_pkt",   32'(a_pkt),   32'(ma.pkt));
      chk("a_gid",   32'(a_gid),   32'(ma.gid));
      chk("a_cnt",   32'(a_cnt),   32'(ma.cnt));
      chk("b_valid", 32'(b_valid), 32'(mb.full));
      chk("b_pkt",   32'(b_pkt),   32'(mb.pkt));
      chk("b_gid",   32'(b_gid),   32'(mb.gid));
      chk("b_cnt",   32'(b_cnt),   32'(mb.cnt));
    end
    mstep(4, 65535, ma, ea);
    mstep(3, 15, mb, eb);
    chk("a_ready", 32'(a_ready), 32'(ea));
    chk("b_ready", 32'(b_ready), 32'(eb[2:0]));
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_dest = '0; req_data = '0; out_ready = 1'b0;

    // Reset with every requester asserting.
    cyc(1, 4'hF, 1);
    chk_en = 1;
    cyc(1, 4'hF, 1);

    // Single request from lane 2.
    req_dest = 16'h0300;
    req_data = 32'h00A5_0000;
    cyc(0, 4'b0100, 1, 1);
    cyc(0, 4'b0000, 1);
    chk("t2_pkt", 32'(a_pkt), 32'h23A5);
    chk("t2_gid", 32'(a_gid), 32'd2);
    chk("t2_pkt_small", 32'(b_pkt), 32'h23A5);

    // rr_ptr is 3 now; only lane 1 requests.
    cyc(0, 4'b0010, 1);
    cyc(0, 4'b0000, 0);
    chk("t5_gid", 32'(a_gid), 32'd1);

    // Fairness from a fresh reset.
    cyc(1, 4'h0, 1);
    for (int i = 0; i < 9; i++) cyc(0, 4'hF, 1);
    cyc(0, 4'hF, 1);
    chk("t3_cnt", 32'(a_cnt), 32'd8);

    // Backpressure then simultaneous drain/reload.
    for (int i = 0; i < 6; i++) cyc(0, 4'hF, 0);
    cyc(0, 4'hF, 1);
    cyc(0, 4'h0, 0);

    // Counter saturation on the 4-bit instance, then reset while full.
    for (int i = 0; i < 20; i++) cyc(0, 4'hF, 1);
    cyc(0, 4'hF, 0);
    chk("t6_sat", 32'(b_cnt), 32'd15);
    cyc(1, 4'hF, 1);
    cyc(0, 4'h0, 0);
    chk("t6_vld", 32'(a_valid), 32'd0);
    chk("t6_cnt", 32'(b_cnt), 32'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 40) == 0), 4'($urandom), ($urandom_range(0, 3) != 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
